// File: rtl/home_inventory_wb_master.sv
// home_inventory_wb_master: single-outstanding Wishbone classic initiator.
// Turns one valid/ready command into one Wishbone cycle and returns the
// read data (or a timeout error) on a valid/ready response stream.
// Optional feature macro: HOME_INVENTORY_WBM_TIMEOUT_EN. When it is defined,
// a cycle counter aborts a BUS cycle that sees no ack for TIMEOUT_CYCLES
// cycles. When it is undefined, BUS waits for ack indefinitely and rsp_err
// is always 0.
module home_inventory_wb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned TO_W           = 16,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic        cyc_reg, cyc_next;
    logic        we_reg, we_next;
    logic [3:0]  sel_reg, sel_next;
    logic [31:0] adr_reg, adr_next;
    logic [31:0] dat_reg, dat_next;
    logic        rsp_valid_reg, rsp_valid_next;
    logic [31:0] rsp_dat_reg, rsp_dat_next;
    logic        rsp_err_reg, rsp_err_next;

`ifdef HOME_INVENTORY_WBM_TIMEOUT_EN
    logic [TO_W-1:0] cnt_reg, cnt_next;
    logic            timeout;

    // Abort once the last allowed BUS cycle has passed without ack.
    assign timeout = (cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));

    // Counter clears when a command is accepted and counts every BUS cycle.
    always_comb begin
        cnt_next = cnt_reg;
        if (state_reg == IDLE && cmd_valid) begin
            cnt_next = '0;
        end else if (state_reg == BUS) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    // Timeout counter register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end
`endif

    // Next-state and next-output logic; every register holds by default.
    always_comb begin
        state_next     = state_reg;
        cyc_next       = cyc_reg;
        we_next        = we_reg;
        sel_next       = sel_reg;
        adr_next       = adr_reg;
        dat_next       = dat_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_dat_next   = rsp_dat_reg;
        rsp_err_next   = rsp_err_reg;
        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    we_next    = cmd_we;
                    sel_next   = cmd_sel;
                    dat_next   = cmd_dat;
                    // Slave decodes word addresses only.
                    adr_next   = cmd_adr & 32'hFFFF_FFFC;
                    cyc_next   = 1'b1;
                    state_next = BUS;
                end
            end
            BUS: begin
                // Ack has priority over a coincident timeout.
                if (wbm_ack_i) begin
                    cyc_next       = 1'b0;
                    rsp_dat_next   = we_reg ? 32'h0 : wbm_dat_i;
                    rsp_err_next   = 1'b0;
                    rsp_valid_next = 1'b1;
                    state_next     = RESP;
                end
`ifdef HOME_INVENTORY_WBM_TIMEOUT_EN
                else if (timeout) begin
                    cyc_next       = 1'b0;
                    rsp_dat_next   = ERR_DATA;
                    rsp_err_next   = 1'b1;
                    rsp_valid_next = 1'b1;
                    state_next     = RESP;
                end
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and registered bus/response outputs; reset drops the cycle at once.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg     <= IDLE;
            cyc_reg       <= 1'b0;
            we_reg        <= 1'b0;
            sel_reg       <= 4'h0;
            adr_reg       <= 32'h0;
            dat_reg       <= 32'h0;
            rsp_valid_reg <= 1'b0;
            rsp_dat_reg   <= 32'h0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cyc_reg       <= cyc_next;
            we_reg        <= we_next;
            sel_reg       <= sel_next;
            adr_reg       <= adr_next;
            dat_reg       <= dat_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_dat_reg   <= rsp_dat_next;
            rsp_err_reg   <= rsp_err_next;
        end
    end

    assign cmd_ready = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign wbm_cyc_o = cyc_reg;
    assign wbm_stb_o = cyc_reg;
    assign wbm_we_o  = we_reg;
    assign wbm_sel_o = sel_reg;
    assign wbm_adr_o = adr_reg;
    assign wbm_dat_o = dat_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_dat   = rsp_dat_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_home_inventory_wb_master.sv
// Testbench for home_inventory_wb_master: a small register-slave model
// (ID, version, IRQ_EN) with a same-cycle ack, a vector table for ordinary
// transactions, and hand-written sequences for timeout, backpressure and reset.
module tb_home_inventory_wb_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = 32'h0;
    logic [31:0] cmd_dat = 32'h0;
    logic [3:0]  cmd_sel = 4'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic        wbm_ack_i;
    logic        busy;

    logic        slave_en  = 1'b1;
    logic        ack_force = 1'b0;
    logic [7:0]  irq_en;

    int errors = 0;
    int checks = 0;

    home_inventory_wb_master dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_adr  (cmd_adr),
        .cmd_dat  (cmd_dat),
        .cmd_sel  (cmd_sel),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_dat  (rsp_dat),
        .rsp_err  (rsp_err),
        .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o),
        .wbm_we_o (wbm_we_o),
        .wbm_sel_o(wbm_sel_o),
        .wbm_adr_o(wbm_adr_o),
        .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i),
        .wbm_ack_i(wbm_ack_i),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Slave model: ack in the same cycle as STB, read mux, IRQ_EN byte 0.
    assign wbm_ack_i = (wbm_cyc_o & wbm_stb_o & slave_en) | ack_force;

    always_comb begin
        wbm_dat_i = 32'h0;
        case (wbm_adr_o)
            32'h0000_0000: wbm_dat_i = 32'h4849_4348;
            32'h0000_0004: wbm_dat_i = 32'h0000_0001;
            32'h0000_0104: wbm_dat_i = {24'h0, irq_en};
            default:       wbm_dat_i = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_en <= 8'h0;
        end else if (wbm_cyc_o && wbm_stb_o && wbm_we_o && wbm_ack_i &&
                     wbm_adr_o == 32'h0000_0104 && wbm_sel_o[0]) begin
            irq_en <= wbm_dat_o[7:0];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Presents one command for one edge (IDLE accepts it) and returns at the
    // falling edge of the first BUS cycle.
    task automatic start_cmd(input logic we, input logic [31:0] adr,
                             input logic [31:0] dat, input logic [3:0] sel);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        chk("cmd_ready_before_accept", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp_adr;
        logic [31:0] exp_rsp;
    } vec_t;

    vec_t vecs[9];

    task automatic run_vec(input int idx, input vec_t v);
        int n;
        start_cmd(v.we, v.adr, v.dat, v.sel);
        chk("wbm_adr", wbm_adr_o, v.exp_adr);
        chk("wbm_we", 32'(wbm_we_o), 32'(v.we));
        chk("wbm_sel", 32'(wbm_sel_o), 32'(v.sel));
        chk("wbm_dat", wbm_dat_o, v.dat);
        n = 0;
        while (wbm_cyc_o && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("cyc_cycles", 32'(n), 32'd1);
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_dat", rsp_dat, v.exp_rsp);
        chk("rsp_err", 32'(rsp_err), 32'd0);
        $display("txn %0d we=%0d adr=%h sel=%h rsp_dat=%h rsp_err=%0d",
                 idx, v.we, v.adr, v.sel, rsp_dat, rsp_err);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_consumed", 32'(rsp_valid), 32'd0);
        chk("cmd_ready_after_rsp", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int n;
        logic [31:0] held;
        //          we    adr            dat            sel   exp_adr        exp_rsp
        vecs[0] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'hF, 32'h0000_0000, 32'h4849_4348};
        vecs[1] = '{1'b1, 32'h0000_0104, 32'hFFFF_FFFF, 4'h1, 32'h0000_0104, 32'h0000_0000};
        vecs[2] = '{1'b0, 32'h0000_0104, 32'h0000_0000, 4'hF, 32'h0000_0104, 32'h0000_00FF};
        vecs[3] = '{1'b0, 32'h0000_0006, 32'h0000_0000, 4'hF, 32'h0000_0004, 32'h0000_0001};
        vecs[4] = '{1'b1, 32'h0000_0104, 32'h1234_5678, 4'h0, 32'h0000_0104, 32'h0000_0000};
        vecs[5] = '{1'b0, 32'h0000_0104, 32'h0000_0000, 4'hF, 32'h0000_0104, 32'h0000_00FF};
        vecs[6] = '{1'b1, 32'h0000_0107, 32'h0000_00A5, 4'h1, 32'h0000_0104, 32'h0000_0000};
        vecs[7] = '{1'b0, 32'h0000_0104, 32'h0000_0000, 4'hF, 32'h0000_0104, 32'h0000_00A5};
        vecs[8] = '{1'b0, 32'h0000_0200, 32'h0000_0000, 4'hF, 32'h0000_0200, 32'h0000_0000};

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("rst_stb", 32'(wbm_stb_o), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_dat", rsp_dat, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_adr", wbm_adr_o, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_vec(i, vecs[i]);
        end

        // Slave never acks.
        slave_en = 1'b0;
        start_cmd(1'b0, 32'h0000_0000, 32'h0, 4'hF);
        n = 0;
`ifdef HOME_INVENTORY_WBM_TIMEOUT_EN
        while (wbm_cyc_o && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("timeout_cyc_cycles", 32'(n), 32'd16);
        chk("timeout_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("timeout_rsp_err", 32'(rsp_err), 32'd1);
        chk("timeout_rsp_dat", rsp_dat, 32'hDEAD_BEEF);
        $display("txn timeout cyc_cycles=%0d rsp_dat=%h rsp_err=%0d", n, rsp_dat, rsp_err);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("timeout_consumed", 32'(rsp_valid), 32'd0);
        start_cmd(1'b0, 32'h0000_0000, 32'h0, 4'hF);
        @(negedge clk);
        @(negedge clk);
`else
        while (wbm_cyc_o && n < 120) begin
            n++;
            @(negedge clk);
        end
        chk("no_timeout_cyc_over_100", 32'(n > 100), 32'd1);
        chk("no_timeout_rsp_valid", 32'(rsp_valid), 32'd0);
        $display("txn hang cyc_cycles=%0d", n);
`endif

        // Asynchronous reset while the cycle is still in BUS.
        chk("pre_rst_cyc", 32'(wbm_cyc_o), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("async_rst_stb", 32'(wbm_stb_o), 32'd0);
        chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        slave_en = 1'b1;
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        // Late ack from the slave must not produce anything.
        ack_force = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("late_ack_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("late_ack_cyc", 32'(wbm_cyc_o), 32'd0);
            chk("late_ack_busy", 32'(busy), 32'd0);
        end
        ack_force = 1'b0;
        $display("txn reset_abort rsp_valid=%0d cmd_ready=%0d", rsp_valid, cmd_ready);

        // Response backpressure with the next command already waiting.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h0000_0000;
        cmd_sel   = 4'hF;
        @(negedge clk);
        cmd_adr = 32'h0000_0006;
        chk("bp_first_cyc", 32'(wbm_cyc_o), 32'd1);
        @(negedge clk);
        held = rsp_dat;
        chk("bp_rsp_dat", held, 32'h4849_4348);
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_dat_stable", rsp_dat, 32'h4849_4348);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("bp_cyc", 32'(wbm_cyc_o), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp_consumed", 32'(rsp_valid), 32'd0);
        chk("bp_no_same_cycle_accept", 32'(wbm_cyc_o), 32'd0);
        chk("bp_cmd_ready_after", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("bp_next_accept_cyc", 32'(wbm_cyc_o), 32'd1);
        chk("bp_next_adr", wbm_adr_o, 32'h0000_0004);
        @(negedge clk);
        chk("bp_next_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("bp_next_rsp_dat", rsp_dat, 32'h0000_0001);
        $display("txn backpressure first=%h next=%h", held, rsp_dat);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp_next_consumed", 32'(rsp_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
